// File: rtl/dmem_pkg.sv
// Shared constants and enums for the dmem DMA engine.
// Holds data/address widths, word stride, FSM states and job modes.
package dmem_pkg;

   localparam int DATA_W      = 16;
   localparam int ADDR_W      = 16;
   localparam int WORD_STRIDE = 2;

   typedef enum logic [1:0] {
      IDLE,
      RD,
      WR,
      DONE
   } state_t;

   typedef enum logic {
      MODE_COPY,
      MODE_FILL
   } mode_t;

endpackage

// File: rtl/dmem_addr_gen.sv
// Loadable wrapping byte-address incrementer (one per DMA pointer).
// Ports: clk, rst_n, load, load_value[R], inc, value[R].
module dmem_addr_gen
   import dmem_pkg::*;
#(
   parameter int R      = ADDR_W,
   parameter int STRIDE = WORD_STRIDE
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [R-1:0] load_value,
   input  logic         inc,
   output logic [R-1:0] value
);

   // Plain R-bit add: carry out is dropped so 0xFFFE + 2 wraps to 0.
   localparam logic [R-1:0] STEP = R'(STRIDE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
      end else if (load) begin
         value <= load_value;
      end else if (inc) begin
         value <= value + STEP;
      end
   end

endmodule

// File: rtl/dmem_dma.sv
// Block COPY / FILL engine driving the single-port 16-bit dmem.
// Ports: clk, rst_n, start/mode/src_addr/dst_addr/len_words/fill_data
// (job request), busy/done/error/words_done (status),
// dmem_addr/dmem_we/dmem_wdata/dmem_rdata (memory port).
module dmem_dma
   import dmem_pkg::*;
#(
   parameter int N      = DATA_W,
   parameter int R      = ADDR_W,
   parameter int STRIDE = WORD_STRIDE
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         mode,
   input  logic [R-1:0] src_addr,
   input  logic [R-1:0] dst_addr,
   input  logic [15:0]  len_words,
   input  logic [N-1:0] fill_data,
   output logic         busy,
   output logic         done,
   output logic         error,
   output logic [15:0]  words_done,
   output logic [R-1:0] dmem_addr,
   output logic         dmem_we,
   output logic [N-1:0] dmem_wdata,
   input  logic [N-1:0] dmem_rdata
);

   state_t      state;
   mode_t       mode_q;
   logic [15:0] remaining;

   logic [R-1:0] src_q;
   logic [R-1:0] dst_q;

   logic aligned;
   logic accept;
   logic ptr_inc;

   assign aligned = ~src_addr[0] & ~dst_addr[0];

   assign accept = (state == IDLE) && start
                && aligned && (len_words != 16'd0);

   assign ptr_inc = (state == WR);

   dmem_addr_gen #(
      .R      (R),
      .STRIDE (STRIDE)
   ) u_src (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (accept),
      .load_value (src_addr),
      .inc        (ptr_inc),
      .value      (src_q)
   );

   dmem_addr_gen #(
      .R      (R),
      .STRIDE (STRIDE)
   ) u_dst (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (accept),
      .load_value (dst_addr),
      .inc        (ptr_inc),
      .value      (dst_q)
   );

   // Both pointers are flops and the select is the state flop, so
   // the address never sees a combinational path from start.
   assign dmem_addr = (state == RD) ? src_q : dst_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         mode_q     <= MODE_COPY;
         remaining  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         words_done <= '0;
         dmem_we    <= 1'b0;
         dmem_wdata <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (!aligned) begin
                     error <= 1'b1;
                  end else if (len_words == 16'd0) begin
                     error      <= 1'b0;
                     words_done <= '0;
                     done       <= 1'b1;
                     state      <= DONE;
                  end else begin
                     error      <= 1'b0;
                     words_done <= '0;
                     remaining  <= len_words;
                     mode_q     <= mode_t'(mode);
                     busy       <= 1'b1;
                     if (mode_t'(mode) == MODE_FILL) begin
                        // The fill pattern lives in the write-data
                        // flop for the whole job.
                        dmem_we    <= 1'b1;
                        dmem_wdata <= fill_data;
                        state      <= WR;
                     end else begin
                        dmem_we <= 1'b0;
                        state   <= RD;
                     end
                  end
               end
            end

            RD: begin
               // Write-data flop doubles as the copy buffer.
               dmem_wdata <= dmem_rdata;
               dmem_we    <= 1'b1;
               state      <= WR;
            end

            WR: begin
               words_done <= words_done + 16'd1;
               remaining  <= remaining - 16'd1;
               if (remaining == 16'd1) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  dmem_we <= 1'b0;
                  state   <= DONE;
               end else if (mode_q == MODE_COPY) begin
                  dmem_we <= 1'b0;
                  state   <= RD;
               end
            end

            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_dma.sv
// Self-checking bench for dmem_dma with a behavioural dmem.
// Expected writes are queued at job start and popped as writes appear.
module tb_dmem_dma;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        mode;
   logic [15:0] src_addr;
   logic [15:0] dst_addr;
   logic [15:0] len_words;
   logic [15:0] fill_data;
   logic        busy;
   logic        done;
   logic        error;
   logic [15:0] words_done;
   logic [15:0] dmem_addr;
   logic        dmem_we;
   logic [15:0] dmem_wdata;
   logic [15:0] dmem_rdata;

   logic [15:0] mem [0:32767];
   logic        pre_we;
   logic [15:0] pre_addr;
   logic [15:0] pre_data;

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] data;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;

   int n_checks;
   int n_fail;
   int busy_cnt;
   int done_cnt;
   int we_cnt;

   dmem_dma dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .mode       (mode),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .len_words  (len_words),
      .fill_data  (fill_data),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .words_done (words_done),
      .dmem_addr  (dmem_addr),
      .dmem_we    (dmem_we),
      .dmem_wdata (dmem_wdata),
      .dmem_rdata (dmem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign dmem_rdata = mem[dmem_addr[15:1]];

   always @(posedge clk) begin
      if (dmem_we) mem[dmem_addr[15:1]] <= dmem_wdata;
      else if (pre_we) mem[pre_addr[15:1]] <= pre_data;
   end

   // Scoreboard: every dmem write must match the next expected one.
   always @(negedge clk) begin
      if (rst_n) begin
         if (busy) busy_cnt++;
         if (done) done_cnt++;
         if (dmem_we) begin
            we_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_write got addr=%h data=%h exp none",
                        dmem_addr, dmem_wdata);
            end else begin
               mon_e = exp_q.pop_front();
               if (dmem_addr !== mon_e.addr || dmem_wdata !== mon_e.data) begin
                  n_fail++;
                  $display("FAIL write got addr=%h data=%h exp addr=%h data=%h",
                           dmem_addr, dmem_wdata, mon_e.addr, mon_e.data);
               end
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic clear_stats();
      busy_cnt = 0;
      done_cnt = 0;
      we_cnt   = 0;
   endtask

   task automatic preload(input logic [15:0] a, input logic [15:0] d);
      @(negedge clk);
      pre_we   = 1'b1;
      pre_addr = a;
      pre_data = d;
      @(posedge clk);
      #1;
      pre_we = 1'b0;
   endtask

   task automatic pulse_start(input logic m, input logic [15:0] s,
                              input logic [15:0] d, input logic [15:0] l,
                              input logic [15:0] f);
      @(posedge clk);
      #1;
      start     = 1'b1;
      mode      = m;
      src_addr  = s;
      dst_addr  = d;
      len_words = l;
      fill_data = f;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #23;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags got busy=%b done=%b error=%b exp 0 0 0",
                  busy, done, error);
      end
      n_checks++;
      if (dmem_we !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_we got %b exp 0", dmem_we);
      end
      n_checks++;
      if (dmem_addr !== 16'h0000 || dmem_wdata !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_dmem got addr=%h wdata=%h exp 0000 0000",
                  dmem_addr, dmem_wdata);
      end
      n_checks++;
      if (words_done !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_words_done got %h exp 0000", words_done);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_fill();
      bit ok;
      logic [15:0] a;
      clear_stats();
      for (int i = 0; i < 4; i++) exp_q.push_back({16'(i * 2), 16'hA5A5});
      pulse_start(1'b1, 16'h0000, 16'h0000, 16'd4, 16'hA5A5);
      wait_done(20, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL fill_timeout got no done exp done");
      end
      n_checks++;
      if (busy_cnt != 4 || done_cnt != 1) begin
         n_fail++;
         $display("FAIL fill_timing got busy=%0d done=%0d exp 4 1",
                  busy_cnt, done_cnt);
      end
      n_checks++;
      if (words_done !== 16'd4) begin
         n_fail++;
         $display("FAIL fill_words_done got %0d exp 4", words_done);
      end
      for (int i = 0; i < 4; i++) begin
         a = 16'(i * 2);
         n_checks++;
         if (mem[a[15:1]] !== 16'hA5A5) begin
            n_fail++;
            $display("FAIL fill_mem[%h] got %h exp a5a5", a, mem[a[15:1]]);
         end
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL fill_missing got %0d pending exp 0", exp_q.size());
      end
   endtask

   task automatic test_copy();
      bit ok;
      logic [15:0] a;
      logic [15:0] v [3];
      v[0] = 16'h1111;
      v[1] = 16'h2222;
      v[2] = 16'h3333;
      for (int i = 0; i < 3; i++) preload(16'(16'h0010 + i * 2), v[i]);
      clear_stats();
      for (int i = 0; i < 3; i++) exp_q.push_back({16'(16'h0100 + i * 2), v[i]});
      pulse_start(1'b0, 16'h0010, 16'h0100, 16'd3, 16'h0000);
      wait_done(30, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL copy_timeout got no done exp done");
      end
      n_checks++;
      if (busy_cnt != 6 || done_cnt != 1 || we_cnt != 3) begin
         n_fail++;
         $display("FAIL copy_timing got busy=%0d done=%0d we=%0d exp 6 1 3",
                  busy_cnt, done_cnt, we_cnt);
      end
      for (int i = 0; i < 3; i++) begin
         a = 16'(16'h0100 + i * 2);
         n_checks++;
         if (mem[a[15:1]] !== v[i]) begin
            n_fail++;
            $display("FAIL copy_dst[%h] got %h exp %h", a, mem[a[15:1]], v[i]);
         end
         a = 16'(16'h0010 + i * 2);
         n_checks++;
         if (mem[a[15:1]] !== v[i]) begin
            n_fail++;
            $display("FAIL copy_src[%h] got %h exp %h", a, mem[a[15:1]], v[i]);
         end
      end
      n_checks++;
      if (words_done !== 16'd3) begin
         n_fail++;
         $display("FAIL copy_words_done got %0d exp 3", words_done);
      end
   endtask

   task automatic test_misaligned();
      bit ok;
      clear_stats();
      pulse_start(1'b0, 16'h0003, 16'h0600, 16'd2, 16'h0000);
      repeat (4) @(negedge clk);
      n_checks++;
      if (error !== 1'b1) begin
         n_fail++;
         $display("FAIL misaligned_error got %b exp 1", error);
      end
      n_checks++;
      if (busy_cnt != 0 || we_cnt != 0 || done_cnt != 0) begin
         n_fail++;
         $display("FAIL misaligned_idle got busy=%0d we=%0d done=%0d exp 0 0 0",
                  busy_cnt, we_cnt, done_cnt);
      end
      exp_q.push_back({16'h0700, 16'h5A5A});
      pulse_start(1'b1, 16'h0000, 16'h0700, 16'd1, 16'h5A5A);
      n_checks++;
      if (error !== 1'b0) begin
         n_fail++;
         $display("FAIL misaligned_clear got %b exp 0", error);
      end
      wait_done(10, ok);
      n_checks++;
      if (!ok || words_done !== 16'd1) begin
         n_fail++;
         $display("FAIL misaligned_followup got ok=%b words=%0d exp 1 1",
                  ok, words_done);
      end
   endtask

   task automatic test_zero_len();
      bit ok;
      clear_stats();
      pulse_start(1'b1, 16'h0000, 16'h0800, 16'd0, 16'hFFFF);
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_len_pulse got done=%b busy=%b exp 1 0", done, busy);
      end
      wait_done(5, ok);
      n_checks++;
      if (!ok || done_cnt != 1 || busy_cnt != 0 || we_cnt != 0) begin
         n_fail++;
         $display("FAIL zero_len_stats got ok=%b done=%0d busy=%0d we=%0d exp 1 1 0 0",
                  ok, done_cnt, busy_cnt, we_cnt);
      end
      n_checks++;
      if (words_done !== 16'd0 || error !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_len_status got words=%0d err=%b exp 0 0",
                  words_done, error);
      end
   endtask

   task automatic test_wrap();
      bit ok;
      clear_stats();
      exp_q.push_back({16'hFFFE, 16'hBEEF});
      exp_q.push_back({16'h0000, 16'hBEEF});
      pulse_start(1'b1, 16'h0000, 16'hFFFE, 16'd2, 16'hBEEF);
      wait_done(10, ok);
      n_checks++;
      if (!ok || busy_cnt != 2 || error !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_timing got ok=%b busy=%0d err=%b exp 1 2 0",
                  ok, busy_cnt, error);
      end
      n_checks++;
      if (mem[15'h7FFF] !== 16'hBEEF || mem[15'h0000] !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL wrap_mem got %h %h exp beef beef",
                  mem[15'h7FFF], mem[15'h0000]);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      logic [15:0] old;
      for (int i = 0; i < 8; i++) preload(16'(16'h0200 + i * 2), 16'(16'h1000 + i));
      clear_stats();
      for (int i = 0; i < 8; i++)
         exp_q.push_back({16'(16'h0300 + i * 2), 16'(16'h1000 + i)});
      pulse_start(1'b0, 16'h0200, 16'h0300, 16'd8, 16'h0000);
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || dmem_we !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_flags got busy=%b done=%b err=%b we=%b exp 0 0 0 0",
                  busy, done, error, dmem_we);
      end
      n_checks++;
      if (dmem_addr !== 16'h0 || dmem_wdata !== 16'h0 || words_done !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_mid_regs got addr=%h wdata=%h words=%h exp 0 0 0",
                  dmem_addr, dmem_wdata, words_done);
      end
      n_checks++;
      if (we_cnt != 2) begin
         n_fail++;
         $display("FAIL reset_mid_writes got %0d exp 2", we_cnt);
      end
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;

      clear_stats();
      old = mem[15'h0280];
      for (int i = 0; i < 3; i++) exp_q.push_back({16'(16'h0400 + i * 2), 16'h1234});
      pulse_start(1'b1, 16'h0000, 16'h0400, 16'd3, 16'h1234);
      pulse_start(1'b1, 16'h0000, 16'h0500, 16'd5, 16'hDEAD);
      wait_done(15, ok);
      n_checks++;
      if (!ok || busy_cnt != 3 || done_cnt != 1) begin
         n_fail++;
         $display("FAIL busy_start got ok=%b busy=%0d done=%0d exp 1 3 1",
                  ok, busy_cnt, done_cnt);
      end
      n_checks++;
      if (words_done !== 16'd3 || error !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_start_status got words=%0d err=%b exp 3 0",
                  words_done, error);
      end
      n_checks++;
      if (mem[15'h0280] !== old || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL busy_start_mem got %h pending=%0d exp %h 0",
                  mem[15'h0280], exp_q.size(), old);
      end
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      mode      = 1'b0;
      src_addr  = '0;
      dst_addr  = '0;
      len_words = '0;
      fill_data = '0;
      pre_we    = 1'b0;
      pre_addr  = '0;
      pre_data  = '0;
      clear_stats();

      test_reset();
      test_fill();
      test_copy();
      test_misaligned();
      test_zero_len();
      test_wrap();
      test_reset_mid();

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_dma.md
Name: dmem_dma

Overview:
- Initiator-side engine that drives the single-port 16-bit data memory (dmem) interface: addr, write_enable, writedata out; readdata in.
- Performs block COPY (src→dst) or block FILL (constant pattern) of N 16-bit words without CPU involvement.
- Sits between the control/CPU side (start/status) and dmem. The dmem port is muxed to this block while busy=1.

Parameters:
- N, 16, data width in bits.
- R, 16, address width in bits (byte addresses, 64 KB space).
- STRIDE, 2, byte increment per word (word-aligned addressing).

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request pulse; sampled only in IDLE.
- mode  in  1  0=COPY, 1=FILL; sampled with start.
- src_addr  in  R  COPY source byte address; sampled with start.
- dst_addr  in  R  destination byte address; sampled with start.
- len_words  in  16  number of words to transfer; sampled with start.
- fill_data  in  N  FILL pattern; sampled with start.
- busy  out  1  high from the cycle after an accepted start through the last write.
- done  out  1  one-cycle pulse at completion, including zero-length completion.
- error  out  1  set on rejected start; cleared by the next accepted start.
- words_done  out  16  count of words written in the current or last job.
- dmem_addr  out  R  address to dmem.
- dmem_we  out  1  dmem write_enable.
- dmem_wdata  out  N  dmem writedata.
- dmem_rdata  in  N  dmem readdata (combinational read of dmem_addr).

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - busy, done, error, dmem_we = 0.
  - dmem_addr, dmem_wdata, words_done = 0.
  - Internal src/dst/remaining registers = 0.
- FSM states:
  - IDLE: on start=1, evaluate the request.
    - If src_addr[0] or dst_addr[0] is 1, reject the job: set error=1, stay IDLE, no dmem access.
    - If len_words=0, accept the job: pulse done the next cycle, never assert busy, clear error.
    - Otherwise, latch all inputs, clear error and words_done, then go to RD (COPY) or WR (FILL).
  - RD (COPY only): dmem_addr=src, dmem_we=0. At the clock edge, capture dmem_rdata into the data buffer and go to WR.
  - WR: dmem_addr=dst, dmem_we=1, dmem_wdata = buffer (COPY) or fill pattern (FILL). At the clock edge:
    - words_done += 1; src += STRIDE; dst += STRIDE; remaining -= 1.
    - If remaining was 1, go to DONE. Else go to RD (COPY) or stay in WR (FILL).
  - DONE: done=1 for exactly one cycle, busy=0, dmem_we=0, then IDLE.
- Throughput: COPY takes 2 cycles per word; FILL takes 1 cycle per word.
  - An accepted job of L words asserts busy for 2L cycles (COPY) or L cycles (FILL).
- dmem_we is high only in WR. All dmem outputs are registered (no combinational path from start).
- Address arithmetic wraps modulo 2^R (0xFFFE + 2 → 0x0000), with no error.
- Overlapping regions are not detected. Copy proceeds in ascending order, word by word.
- start while busy or in DONE is ignored: no state change, no error.
- rst_n asserted mid-job aborts immediately to reset values. The word being written that cycle may or may not land.
- words_done holds its final value in IDLE until the next accepted start.

Decomposition:
- Package dmem_pkg holds:
  - DATA_W=16 and ADDR_W=16 constants;
  - WORD_STRIDE=2;
  - the state enum {IDLE, RD, WR, DONE};
  - the mode enum {MODE_COPY, MODE_FILL}.
- Sub-module dmem_addr_gen is natural: a loadable R-bit wrapping incrementer (load, inc, value), instantiated twice for src and dst. All other logic lives in dmem_dma.
- The bench instantiates dmem_dma wired to the existing dmem.

Test Plan:
- FILL: dst=0x0000, len=4, fill_data=0xA5A5 → 4 consecutive write cycles at 0x0000, 0x0002, 0x0004, 0x0006. dmem reads back 0xA5A5 at each; busy high 4 cycles; done pulses once; words_done=4.
- COPY: preload dmem 0x0010..0x0014 = 0x1111, 0x2222, 0x3333; src=0x0010, dst=0x0100, len=3 → dmem 0x0100..0x0104 = 0x1111, 0x2222, 0x3333; busy high 6 cycles; source words unchanged.
- Misaligned start (src=0x0003) → error=1, busy stays 0, no dmem_we. A following valid start clears error.
- len_words=0 → done pulses the cycle after start, busy never asserts, dmem_we never asserts.
- Wrap: FILL dst=0xFFFE, len=2, fill=0xBEEF → writes at 0xFFFE then 0x0000, both 0xBEEF.
- Async reset mid-COPY of len=8 after 5 cycles → all outputs return to 0 immediately. A new start afterward behaves normally; start pulsed while busy is ignored.
